// File: rtl/temporizador_arbitro.sv
// temporizador_arbitro: shared seconds timer for the problema_03 control path.
//
// Owns the 1 Hz prescaler and time-shares it between requester A (main FSM
// stop phase) and requester B (password-wait FSM). A granted requester gets
// its duration loaded and counted down in whole seconds, with a per-second
// tick and a one-cycle done pulse at the end.
//
// Ports:
//   clock, reset_n          system clock, asynchronous active-low reset
//   req_a/dur_a             request + duration (s) from A, duration sampled at grant
//   req_b/dur_b             request + duration (s) from B, duration sampled at grant
//   pausa                   (only with TEMPORIZADOR_PAUSA_EN) stall the countdown
//   grant_a/grant_b         current owner of the timer
//   busy                    high while counting or signalling done
//   tick_1hz                one-cycle pulse per elapsed second
//   seg_rest                remaining seconds for the current owner
//   done_a/done_b           one-cycle pulse when the owner's countdown ends
//
// Optional feature macro: TEMPORIZADOR_PAUSA_EN (adds the pausa input).
// All outputs are registered.
module temporizador_arbitro #(
   parameter int CLK_HZ = 50000000,
   parameter int SEC_W  = 6
) (
   input  logic             clock,
   input  logic             reset_n,
`ifdef TEMPORIZADOR_PAUSA_EN
   input  logic             pausa,
`endif
   input  logic             req_a,
   input  logic [SEC_W-1:0] dur_a,
   input  logic             req_b,
   input  logic [SEC_W-1:0] dur_b,
   output logic             grant_a,
   output logic             grant_b,
   output logic             busy,
   output logic             tick_1hz,
   output logic [SEC_W-1:0] seg_rest,
   output logic             done_a,
   output logic             done_b
);

   localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic [SEC_W-1:0] seg_q, seg_d;
   logic             last_b_q, last_b_d;   // 1: B owned the timer last
   logic             grant_a_q, grant_a_d;
   logic             grant_b_q, grant_b_d;
   logic             busy_q, busy_d;
   logic             tick_q, tick_d;
   logic             done_a_q, done_a_d;
   logic             done_b_q, done_b_d;

   logic hold;
   logic pick_a;
   logic owner_req;

`ifdef TEMPORIZADOR_PAUSA_EN
   assign hold = pausa;
`else
   assign hold = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      presc_d   = presc_q;
      seg_d     = seg_q;
      last_b_d  = last_b_q;
      grant_a_d = grant_a_q;
      grant_b_d = grant_b_q;
      busy_d    = busy_q;
      tick_d    = 1'b0;
      done_a_d  = 1'b0;
      done_b_d  = 1'b0;
      // Round-robin: on contention A wins only if B owned the timer last.
      pick_a    = req_a && (!req_b || last_b_q);
      owner_req = grant_a_q ? req_a : req_b;

      case (state_q)
         S_IDLE: begin
            presc_d = '0;
            if (req_a || req_b) begin
               state_d   = S_RUN;
               grant_a_d = pick_a;
               grant_b_d = !pick_a;
               busy_d    = 1'b1;
               seg_d     = pick_a ? dur_a : dur_b;
               last_b_d  = !pick_a;
            end
         end
         S_RUN: begin
            if (!owner_req) begin
               // Owner walked away: silent abort, no done pulse.
               state_d   = S_IDLE;
               grant_a_d = 1'b0;
               grant_b_d = 1'b0;
               busy_d    = 1'b0;
               seg_d     = '0;
               presc_d   = '0;
            end else if (seg_q == '0) begin
               // Zero duration loaded: finish after a single RUN cycle.
               state_d  = S_DONE;
               done_a_d = grant_a_q;
               done_b_d = grant_b_q;
            end else if (!hold) begin
               if (presc_q == PRESC_MAX) begin
                  presc_d = '0;
                  tick_d  = 1'b1;
                  seg_d   = seg_q - SEC_W'(1);
                  if (seg_q == SEC_W'(1)) begin
                     state_d  = S_DONE;
                     done_a_d = grant_a_q;
                     done_b_d = grant_b_q;
                  end
               end else begin
                  presc_d = presc_q + PW'(1);
               end
            end
         end
         S_DONE: begin
            state_d   = S_IDLE;
            grant_a_d = 1'b0;
            grant_b_d = 1'b0;
            busy_d    = 1'b0;
            presc_d   = '0;
         end
         default: begin
            state_d   = S_IDLE;
            grant_a_d = 1'b0;
            grant_b_d = 1'b0;
            busy_d    = 1'b0;
            seg_d     = '0;
            presc_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         presc_q   <= '0;
         seg_q     <= '0;
         last_b_q  <= 1'b1;
         grant_a_q <= 1'b0;
         grant_b_q <= 1'b0;
         busy_q    <= 1'b0;
         tick_q    <= 1'b0;
         done_a_q  <= 1'b0;
         done_b_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         seg_q     <= seg_d;
         last_b_q  <= last_b_d;
         grant_a_q <= grant_a_d;
         grant_b_q <= grant_b_d;
         busy_q    <= busy_d;
         tick_q    <= tick_d;
         done_a_q  <= done_a_d;
         done_b_q  <= done_b_d;
      end
   end

   assign grant_a  = grant_a_q;
   assign grant_b  = grant_b_q;
   assign busy     = busy_q;
   assign tick_1hz = tick_q;
   assign seg_rest = seg_q;
   assign done_a   = done_a_q;
   assign done_b   = done_b_q;

endmodule

// File: tb/tb_temporizador_arbitro.sv
// Scoreboard bench for temporizador_arbitro (CLK_HZ=10, SEC_W=6).
// Stimulus pushes expected tick/done events (cycle, seg_rest) into a queue;
// a negedge monitor pops and compares whenever the DUT pulses an event.
module tb_temporizador_arbitro;

   localparam int CLK_HZ = 10;
   localparam int SEC_W  = 6;

   logic             clock;
   logic             reset_n;
   logic             req_a, req_b;
   logic [SEC_W-1:0] dur_a, dur_b;
   logic             grant_a, grant_b, busy, tick_1hz, done_a, done_b;
   logic [SEC_W-1:0] seg_rest;
`ifdef TEMPORIZADOR_PAUSA_EN
   logic             pausa;
`endif

   temporizador_arbitro #(.CLK_HZ(CLK_HZ), .SEC_W(SEC_W)) dut (
      .clock    (clock),
      .reset_n  (reset_n),
`ifdef TEMPORIZADOR_PAUSA_EN
      .pausa    (pausa),
`endif
      .req_a    (req_a),
      .dur_a    (dur_a),
      .req_b    (req_b),
      .dur_b    (dur_b),
      .grant_a  (grant_a),
      .grant_b  (grant_b),
      .busy     (busy),
      .tick_1hz (tick_1hz),
      .seg_rest (seg_rest),
      .done_a   (done_a),
      .done_b   (done_b)
   );

   typedef struct packed {
      logic             tick;
      logic             da;
      logic             db;
      logic             ga;
      logic             gb;
      logic [SEC_W-1:0] seg;
      logic [31:0]      cyc;
   } ev_t;

   ev_t         exp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] cyc = 0;
   logic [31:0] g;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Monitor: every observed tick/done pulse must match the queue head.
   always @(negedge clock) begin
      if (tick_1hz || done_a || done_b) begin
         ev_t o, e;
         o = '{tick: tick_1hz, da: done_a, db: done_b, ga: grant_a,
               gb: grant_b, seg: seg_rest, cyc: cyc};
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event cyc=%0d tick=%b da=%b db=%b seg=%0d",
                     cyc, tick_1hz, done_a, done_b, seg_rest);
         end else begin
            e = exp_q.pop_front();
            if (o != e)
               begin
                  n_bad++;
                  $display("FAIL event got cyc=%0d t/da/db/ga/gb=%b%b%b%b%b seg=%0d want cyc=%0d t/da/db/ga/gb=%b%b%b%b%b seg=%0d",
                           o.cyc, o.tick, o.da, o.db, o.ga, o.gb, o.seg,
                           e.cyc, e.tick, e.da, e.db, e.ga, e.gb, e.seg);
               end
         end
      end
   end

   task automatic push(input logic t, input logic da, input logic db,
                       input logic ga, input logic gb,
                       input int seg, input logic [31:0] c);
      exp_q.push_back('{tick: t, da: da, db: db, ga: ga, gb: gb,
                        seg: SEC_W'(seg), cyc: c});
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s got=%0d want=%0d (cyc=%0d)", name, act, want, cyc);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_idle(input string name);
      chk({name, "_outs"}, {28'd0, grant_a, grant_b, busy, done_a | done_b | tick_1hz}, 32'd0);
      chk({name, "_seg"}, 32'(seg_rest), 32'd0);
   endtask

   initial begin
      reset_n = 1'b0;
      req_a = 1'b0; req_b = 1'b0; dur_a = '0; dur_b = '0;
`ifdef TEMPORIZADOR_PAUSA_EN
      pausa = 1'b0;
`endif
      #12;
      chk_idle("reset");
      reset_n = 1'b1;
      step();

      // 1) A alone, 3 s: ticks at +10/+20/+30, done at +30, grant drops at +31.
      req_a = 1'b1; dur_a = 6'd3;
      step(); g = cyc;
      chk("t1_grant_a", 32'(grant_a), 1);
      chk("t1_busy", 32'(busy), 1);
      chk("t1_seg", 32'(seg_rest), 3);
      push(1, 0, 0, 1, 0, 2, g + 10);
      push(1, 0, 0, 1, 0, 1, g + 20);
      push(1, 1, 0, 1, 0, 0, g + 30);
      repeat (30) step();
      req_a = 1'b0;
      step();
      chk_idle("t1_after");

      // 2) Contention right after reset: A first, then B round-robin.
      reset_n = 1'b0; #2; reset_n = 1'b1;
      req_a = 1'b1; req_b = 1'b1; dur_a = 6'd2; dur_b = 6'd1;
      step(); g = cyc;
      chk("t2_grant_a", 32'(grant_a), 1);
      chk("t2_grant_b_low", 32'(grant_b), 0);
      push(1, 0, 0, 1, 0, 1, g + 10);
      push(1, 1, 0, 1, 0, 0, g + 20);
      repeat (20) step();
      step();
      chk("t2_gap_grants", 32'({grant_a, grant_b}), 0);
      step();
      chk("t2_grant_b", 32'(grant_b), 1);
      chk("t2_grant_a_low", 32'(grant_a), 0);
      chk("t2_seg_b", 32'(seg_rest), 1);
      push(1, 0, 1, 0, 1, 0, g + 32);
      repeat (10) step();
      req_a = 1'b0; req_b = 1'b0;
      step();
      chk_idle("t2_after");

      // 3) B with zero duration: one RUN cycle, done without a tick.
      req_b = 1'b1; dur_b = 6'd0;
      step(); g = cyc;
      chk("t3_grant_b", 32'(grant_b), 1);
      push(0, 0, 1, 0, 1, 0, g + 1);
      step();
      req_b = 1'b0;
      step();
      chk_idle("t3_after");

      // 4) A drops request at cycle 25 of a 5 s countdown: silent abort,
      //    then a fresh grant gets a full 10-cycle first second.
      req_a = 1'b1; dur_a = 6'd5;
      step(); g = cyc;
      push(1, 0, 0, 1, 0, 4, g + 10);
      push(1, 0, 0, 1, 0, 3, g + 20);
      repeat (24) step();
      req_a = 1'b0;
      step();
      chk_idle("t4_abort");
      req_a = 1'b1;
      step(); g = cyc;
      chk("t4_regrant", 32'(grant_a), 1);
      chk("t4_reseg", 32'(seg_rest), 5);
      push(1, 0, 0, 1, 0, 4, g + 10);
      repeat (10) step();
      req_a = 1'b0;
      step();
      chk_idle("t4_abort2");

      // 5) Async reset at cycle 15 of a 4 s countdown: immediate clear, no done.
      req_a = 1'b1; dur_a = 6'd4;
      step(); g = cyc;
      push(1, 0, 0, 1, 0, 3, g + 10);
      repeat (14) step();
      #2 reset_n = 1'b0;
      #1;
      chk_idle("t5_async_rst");
      req_a = 1'b0;
      step();
      reset_n = 1'b1;
      repeat (40) step();
      chk_idle("t5_after");

`ifdef TEMPORIZADOR_PAUSA_EN
      // 6) Pause for 7 cycles from cycle 5: tick at +17, done at +27.
      req_a = 1'b1; dur_a = 6'd2;
      step(); g = cyc;
      push(1, 0, 0, 1, 0, 1, g + 17);
      push(1, 1, 0, 1, 0, 0, g + 27);
      repeat (5) step();
      pausa = 1'b1;
      repeat (7) step();
      chk("t6_hold_grant", 32'(grant_a), 1);
      chk("t6_hold_seg", 32'(seg_rest), 2);
      pausa = 1'b0;
      repeat (15) step();
      req_a = 1'b0;
      step();
      chk_idle("t6_after");
`endif

      repeat (3) step();
      chk("events_pending", 32'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/temporizador_arbitro.md
Name: temporizador_arbitro

Overview:
- Shared seconds-timer controller for the problema_03 control path. It owns the 1 Hz prescaler and time-shares it between two requesters.
- Requester A is the main FSM stop ("pare") phase. Requester B is the password-wait FSM.
- It grants the timer to one requester, loads that requester's duration, and counts down in whole seconds. It emits a per-second tick and a one-cycle done pulse to the owner.
- The prescaler runs only while a countdown is active; otherwise it is held at zero.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz; number of clock cycles per tick. Must be >= 2.
- SEC_W, 6, width of duration and remaining-seconds fields.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req_a  in  1  timer request, requester A (pare phase)
- dur_a  in  SEC_W  duration in seconds for A; sampled at grant
- req_b  in  1  timer request, requester B (password wait)
- dur_b  in  SEC_W  duration in seconds for B; sampled at grant
- grant_a  out  1  A owns the timer
- grant_b  out  1  B owns the timer
- busy  out  1  high in RUN or DONE
- tick_1hz  out  1  one-cycle pulse per elapsed second while RUN
- seg_rest  out  SEC_W  remaining seconds for the current owner
- done_a  out  1  one-cycle pulse: A's countdown finished
- done_b  out  1  one-cycle pulse: B's countdown finished

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, prescaler=0, seg_rest=0.
  - All grants, done pulses, tick_1hz and busy are 0.
  - last_owner=B, so A wins the first contention.
  - Reset mid-countdown aborts silently with no done pulse.
- FSM states: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - On a clock edge with any req high, go to RUN.
  - Grant goes to the sole requester. If both request, grant goes to the one that is not last_owner (round-robin).
  - Latch the granted dur_x into seg_rest, clear the prescaler, set last_owner.
  - grant_x and busy rise the cycle after the request is sampled.
- RUN:
  - Prescaler counts 0..CLK_HZ-1 and wraps.
  - On wrap, tick_1hz=1 for one cycle and seg_rest decrements. The first tick occurs exactly CLK_HZ cycles after grant rises.
  - When seg_rest reaches 0 (decrement from 1), go to DONE on the same edge.
  - dur=0 at grant: RUN lasts one cycle, no tick, then DONE.
  - Owner drops req during RUN: abort to IDLE next edge. No done pulse, grant falls, seg_rest=0, prescaler=0.
  - The other requester's req is ignored during RUN (no preemption).
- DONE:
  - done_x=1 for exactly one cycle. grant_x stays high during DONE.
  - Next edge: go to IDLE and drop grant_x and busy.
  - The owner is expected to drop req on seeing done_x. If it is still high in IDLE, it is re-arbitrated normally; it loses to a pending other requester.
- Arithmetic:
  - Prescaler width is clog2(CLK_HZ).
  - seg_rest never underflows; decrement only when nonzero.
  - dur inputs changing during RUN have no effect.
- At most one grant is high at any time. done_a and done_b are never high together.

Optional Feature:
- Macro: TEMPORIZADOR_PAUSA_EN.
- Defined:
  - Adds input port pausa (1 bit).
  - While pausa=1 in RUN, prescaler and seg_rest hold, no tick is emitted, and grant is retained.
  - Owner dropping req still aborts while paused.
  - pausa is ignored in IDLE and DONE.
- Undefined: port absent; countdown never stalls.

Test Plan (CLK_HZ=10, SEC_W=6 for simulation):
- Only req_a with dur_a=3 → grant_a next cycle; tick_1hz at +10, +20, +30 cycles from grant; seg_rest 3→2→1→0; done_a one cycle at +30; grant_a low at +31.
- req_a and req_b rise together after reset, dur_a=2, dur_b=1 → A granted first. After done_a, with both still high, B is granted next. done_b arrives 10 cycles after grant_b.
- req_b with dur_b=0 → grant_b, then done_b two cycles after request sampled; no tick_1hz.
- req_a with dur_a=5, req_a dropped at cycle 25 → back to IDLE with no done_a; seg_rest=0; a new request then sees its first tick a full 10 cycles after grant.
- reset_n pulsed low at cycle 15 of a dur=4 countdown → all outputs 0 immediately (asynchronously); no done pulse after release.
- With TEMPORIZADOR_PAUSA_EN: dur_a=2, pausa high for 7 cycles starting at cycle 5 → first tick at cycle 17, done_a at cycle 27.
